// File: rtl/unidad_control_multiciclo.sv
// Multicycle control FSM for the PG1 datapath: FETCH/DECODE/EXEC/MEM/WB with held mux selects.
// Define UC_MEM_TIMEOUT_EN to fault when data memory does not answer within MEM_TIMEOUT cycles.
module unidad_control_multiciclo #(
  parameter int OPW         = 5,
  parameter int ALUOPW      = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter logic [ALUOPW-1:0] SUB_CODE = ALUOPW'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic              STOP,
  input  logic              INSTR_VALID,
  input  logic [OPW-1:0]    OPCODE,
  input  logic [ALUOPW-1:0] ALUOP,
  input  logic              ZERO,
  input  logic              MEM_READY,
  output logic              FETCH_REQ,
  output logic              IR_LOAD,
  output logic              PC_INC,
  output logic              MEM_REQ,
  output logic              WE,
  output logic              RWrite,
  output logic              Branch,
  output logic              DataInputS,
  output logic              DataInputON,
  output logic              OpbSelect,
  output logic              SelectMem,
  output logic              R2S,
  output logic [ALUOPW-1:0] ALUSignal,
  output logic              BUSY,
  output logic              FAULT,
  output logic              ILLEGAL
);

  // state    | meaning
  // S_IDLE   | waiting for START
  // S_FETCH  | requesting instruction, latch fields on INSTR_VALID
  // S_DECODE | IR load / PC increment, opcode legality check
  // S_EXEC   | ALU operation; BEQ resolves branch here
  // S_MEM    | data memory access (LDR/STR)
  // S_WB     | register-file write
  // S_FAULT  | sticky fault, only rst leaves
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDR  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_STR  = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b00100);

  state_t              state, state_nxt, after_instr;
  logic [OPW-1:0]      op_q;
  logic [ALUOPW-1:0]   alu_q;
  logic                ill_q;
  logic                is_r, is_addi, is_ldr, is_str, is_beq, legal, in_instr;

  assign is_r     = (op_q == OP_R);
  assign is_addi  = (op_q == OP_ADDI);
  assign is_ldr   = (op_q == OP_LDR);
  assign is_str   = (op_q == OP_STR);
  assign is_beq   = (op_q == OP_BEQ);
  assign legal    = is_r | is_addi | is_ldr | is_str | is_beq;
  assign in_instr = (state == S_DECODE) | (state == S_EXEC) | (state == S_MEM) | (state == S_WB);

`ifdef UC_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == CW'(MEM_TIMEOUT));

  // Cleared whenever outside MEM, so every MEM entry starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  tmo_cnt <= '0;
    else if (state != S_MEM)                  tmo_cnt <= '0;
    else if (!MEM_READY && !tmo_hit)          tmo_cnt <= tmo_cnt + CW'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      alu_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && INSTR_VALID) begin
        op_q  <= OPCODE;
        alu_q <= ALUOP;
      end
      if (state == S_DECODE && !legal) ill_q <= 1'b1;
    end
  end

  always_comb begin
    after_instr = STOP ? S_IDLE : S_FETCH;
    state_nxt   = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_FETCH;
      S_FETCH:  if (INSTR_VALID) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (is_beq)                state_nxt = after_instr;
        else if (is_ldr || is_str) state_nxt = S_MEM;
        else                       state_nxt = S_WB;
      end
      S_MEM: begin
        if (MEM_READY)    state_nxt = is_ldr ? S_WB : after_instr;
`ifdef UC_MEM_TIMEOUT_EN
        else if (tmo_hit) state_nxt = S_FAULT;
`endif
      end
      S_WB:     state_nxt = after_instr;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    DataInputS  = 1'b0;
    DataInputON = 1'b0;
    OpbSelect   = 1'b0;
    SelectMem   = 1'b0;
    R2S         = 1'b0;
    ALUSignal   = '0;
    if (in_instr && legal) begin
      if (is_r) begin
        {DataInputS, DataInputON} = 2'b11;
        ALUSignal = alu_q;
      end
      if (is_addi) {DataInputS, DataInputON, OpbSelect} = 3'b111;
      if (is_ldr)  {DataInputON, OpbSelect, SelectMem} = 3'b111;
      if (is_str)  {DataInputS, OpbSelect} = 2'b11;
      if (is_beq) begin
        {DataInputS, DataInputON, R2S} = 3'b111;
        ALUSignal = SUB_CODE;
      end
    end
  end

  always_comb begin
    FETCH_REQ = (state == S_FETCH);
    IR_LOAD   = (state == S_DECODE);
    PC_INC    = (state == S_DECODE);
    MEM_REQ   = (state == S_MEM);
    WE        = (state == S_MEM) && is_str;
    RWrite    = (state == S_WB);
    // Only input-to-output path: ZERO gated by EXEC of a BEQ.
    Branch    = (state == S_EXEC) && is_beq && ZERO;
    BUSY      = (state != S_IDLE);
    FAULT     = (state == S_FAULT);
    ILLEGAL   = ill_q;
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: per-cycle expected output vectors through a scoreboard queue.
module tb_unidad_control_multiciclo;

  localparam logic [4:0] OP_R = 5'b00000, OP_ADDI = 5'b00100, OP_LDR = 5'b00001,
                         OP_STR = 5'b00010, OP_BEQ = 5'b00011, OP_BAD = 5'b11111;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DEC = 2, ST_EXE = 3, ST_MEM = 4, ST_WB = 5, ST_FLT = 6;

  logic       clk, rst, START, STOP, INSTR_VALID, ZERO, MEM_READY;
  logic [4:0] OPCODE;
  logic [2:0] ALUOP, ALUSignal;
  logic FETCH_REQ, IR_LOAD, PC_INC, MEM_REQ, WE, RWrite, Branch;
  logic DataInputS, DataInputON, OpbSelect, SelectMem, R2S, BUSY, FAULT, ILLEGAL;

  unidad_control_multiciclo dut (
    .clk(clk), .rst(rst), .START(START), .STOP(STOP), .INSTR_VALID(INSTR_VALID),
    .OPCODE(OPCODE), .ALUOP(ALUOP), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .FETCH_REQ(FETCH_REQ), .IR_LOAD(IR_LOAD), .PC_INC(PC_INC), .MEM_REQ(MEM_REQ),
    .WE(WE), .RWrite(RWrite), .Branch(Branch), .DataInputS(DataInputS),
    .DataInputON(DataInputON), .OpbSelect(OpbSelect), .SelectMem(SelectMem), .R2S(R2S),
    .ALUSignal(ALUSignal), .BUSY(BUSY), .FAULT(FAULT), .ILLEGAL(ILLEGAL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {FETCH_REQ, IR_LOAD, PC_INC, MEM_REQ, WE, RWrite, Branch,
                DataInputS, DataInputON, OpbSelect, SelectMem, R2S, ALUSignal,
                BUSY, FAULT, ILLEGAL};

  logic [17:0] sb[$];
  int checks = 0, errors = 0;
  logic [4:0] m_op;
  logic [2:0] m_alu;
  logic       m_z, m_ill;

  // Reference output vector for a given state of the instruction in m_op.
  function automatic logic [17:0] ev(input int st);
    logic [4:0] sel;
    logic [2:0] a;
    logic [6:0] stb;
    logic       legal;
    sel = '0;
    a   = '0;
    legal = m_op inside {OP_R, OP_ADDI, OP_LDR, OP_STR, OP_BEQ};
    if (legal && (st == ST_DEC || st == ST_EXE || st == ST_MEM || st == ST_WB)) begin
      case (m_op)
        OP_R:    begin sel = 5'b11000; a = m_alu; end
        OP_ADDI: sel = 5'b11100;
        OP_LDR:  sel = 5'b01110;
        OP_STR:  sel = 5'b10100;
        OP_BEQ:  begin sel = 5'b11001; a = 3'b001; end
        default: sel = '0;
      endcase
    end
    stb = {st == ST_FETCH, st == ST_DEC, st == ST_DEC, st == ST_MEM,
           (st == ST_MEM) && (m_op == OP_STR), st == ST_WB,
           (st == ST_EXE) && (m_op == OP_BEQ) && m_z};
    return {stb, sel, a, st != ST_IDLE, st == ST_FLT, m_ill};
  endfunction

  task automatic compare(input string tag);
    logic [17:0] e;
    e = sb.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic step(input int st, input string tag);
    sb.push_back(ev(st));
    @(negedge clk); #1;
    compare(tag);
  endtask

  task automatic chk_now(input int st, input string tag);
    sb.push_back(ev(st));
    #1;
    compare(tag);
  endtask

  // One full instruction starting from IDLE or from the last state of the previous one.
  task automatic instr(input logic [4:0] op, input logic [2:0] alu, input logic z,
                       input int waits, input logic stop);
    OPCODE = op; ALUOP = alu; ZERO = z; INSTR_VALID = 1'b1;
    START = 1'b1; STOP = 1'b0; MEM_READY = 1'b1;
    m_op = op; m_alu = alu; m_z = z;
    step(ST_FETCH, "fetch");
    START = 1'b0;
    step(ST_DEC, "decode");
    if (!(op inside {OP_R, OP_ADDI, OP_LDR, OP_STR, OP_BEQ})) begin
      m_ill = 1'b1;
      step(ST_FLT, "illegal_fault");
    end else begin
      STOP = stop;
      step(ST_EXE, "exec");
      if (op == OP_LDR || op == OP_STR) begin
        MEM_READY = 1'b0;
        for (int i = 0; i <= waits; i++) begin
          step(ST_MEM, "mem");
          MEM_READY = (i == waits);
        end
      end
      if (op inside {OP_R, OP_ADDI, OP_LDR}) step(ST_WB, "wb");
      if (stop) begin
        step(ST_IDLE, "stop_to_idle");
        step(ST_IDLE, "stop_in_idle");
        STOP = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; START = 1'b0; STOP = 1'b0; INSTR_VALID = 1'b0; ZERO = 1'b0;
    MEM_READY = 1'b0; OPCODE = '0; ALUOP = '0;
    m_op = '0; m_alu = '0; m_z = 1'b0; m_ill = 1'b0;
    #2 chk_now(ST_IDLE, "reset");
    @(negedge clk); rst = 1'b0;
    step(ST_IDLE, "idle_hold");

    instr(OP_R,    3'b101, 1'b0, 0, 1'b0);
    instr(OP_LDR,  3'b011, 1'b0, 3, 1'b0);
    instr(OP_STR,  3'b000, 1'b1, 1, 1'b0);
    instr(OP_BEQ,  3'b110, 1'b1, 0, 1'b0);
    instr(OP_BEQ,  3'b110, 1'b0, 0, 1'b0);
    instr(OP_ADDI, 3'b111, 1'b0, 0, 1'b1);
    instr(OP_LDR,  3'b000, 1'b0, 0, 1'b1);

`ifdef UC_MEM_TIMEOUT_EN
    OPCODE = OP_LDR; m_op = OP_LDR; m_alu = '0; m_z = 1'b0;
    INSTR_VALID = 1'b1; START = 1'b1; MEM_READY = 1'b0;
    step(ST_FETCH, "tmo_fetch");
    START = 1'b0;
    step(ST_DEC, "tmo_decode");
    step(ST_EXE, "tmo_exec");
    repeat (16) step(ST_MEM, "tmo_mem");
    step(ST_FLT, "tmo_fault");
    rst = 1'b1;
    chk_now(ST_IDLE, "tmo_rst");
    @(negedge clk); rst = 1'b0;
`else
    instr(OP_LDR, 3'b000, 1'b0, 20, 1'b1);
`endif

    OPCODE = OP_STR; m_op = OP_STR; m_alu = '0; m_z = 1'b0;
    INSTR_VALID = 1'b1; START = 1'b1; MEM_READY = 1'b0;
    step(ST_FETCH, "abort_fetch");
    START = 1'b0;
    step(ST_DEC, "abort_decode");
    step(ST_EXE, "abort_exec");
    step(ST_MEM, "abort_mem1");
    step(ST_MEM, "abort_mem2");
    rst = 1'b1;
    chk_now(ST_IDLE, "rst_in_mem");
    @(negedge clk); rst = 1'b0;
    step(ST_IDLE, "after_abort_idle");

    instr(OP_BAD, 3'b000, 1'b0, 0, 1'b0);
    START = 1'b1;
    step(ST_FLT, "fault_start_ignored");
    step(ST_FLT, "fault_sticky");
    START = 1'b0;
    rst = 1'b1; m_ill = 1'b0;
    chk_now(ST_IDLE, "rst_clears_fault");
    @(negedge clk); rst = 1'b0;
    step(ST_IDLE, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
